// File: rtl/mpc_dot_acc_36s_21s.sv
// ---------------------------------------------------------------------------
// mpc_dot_acc_36s_21s
//
// Dot-product accumulator placed directly after the 21s x 15ns -> 36-bit
// multiplier of the implicit-MPC datapath. It sums N_TERMS signed products
// per matrix row, rescales the row sum to a signed OUT_WIDTH fixed-point
// value (round half toward +inf, then saturate) and offers the result on a
// one-entry valid/ready output register.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset, clears all state
//   ce         in   clock enable; 0 freezes all registers and both handshakes
//   in_data    in   IN_WIDTH signed product from the multiplier
//   in_valid   in   in_data is valid
//   in_ready   out  product is accepted this cycle (combinational)
//   out_data   out  OUT_WIDTH rounded, saturated row result (registered)
//   out_sat    out  out_data was clamped (registered)
//   out_valid  out  out_data/out_sat hold a result (registered)
//   out_ready  in   consumer takes the result
//   busy       out  a row is partially accumulated (registered count != 0)
// ---------------------------------------------------------------------------
module mpc_dot_acc_36s_21s #(
    parameter int N_TERMS   = 8,
    parameter int IN_WIDTH  = 36,
    parameter int ACC_WIDTH = 42,
    parameter int SHIFT     = 14,
    parameter int OUT_WIDTH = 21
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ce,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_sat,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy
);

    // Term counter width; N_TERMS >= 2 keeps this at least one bit.
    localparam int CNT_W = $clog2(N_TERMS);

    // The rounding add is done one bit wider than the accumulator so the
    // half-LSB offset can never wrap, whatever the row sum.
    localparam int RND_W = ACC_WIDTH + 1;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    localparam logic [ACC_WIDTH-1:0] ACC_ZERO = ACC_WIDTH'(0);
    localparam logic [OUT_WIDTH-1:0] OUT_ZERO = OUT_WIDTH'(0);

    // Half an output LSB expressed in accumulator LSBs: 2^(SHIFT-1).
    localparam logic signed [RND_W-1:0] HALF_LSB = RND_W'(1) << (SHIFT - 1);

    // Largest and smallest representable OUT_WIDTH results, widened to RND_W.
    localparam logic signed [RND_W-1:0] OUT_MAX =
        {{(RND_W - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [RND_W-1:0] OUT_MIN =
        {{(RND_W - OUT_WIDTH + 1){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

    // ------------------------------------------------------------------
    // Rescale a row sum: add half an output LSB, arithmetic-shift away the
    // fractional bits, then clamp to the OUT_WIDTH signed range.
    // Returns {sat, data}.
    // ------------------------------------------------------------------
    function automatic logic [OUT_WIDTH:0] rescale(
        input logic signed [ACC_WIDTH-1:0] sum
    );
        logic signed [RND_W-1:0] rnd;
        logic signed [RND_W-1:0] shifted;
        logic [OUT_WIDTH-1:0]    data;
        logic                    sat;
        rnd     = $signed({sum[ACC_WIDTH-1], sum}) + HALF_LSB;
        shifted = rnd >>> SHIFT;
        if (shifted > OUT_MAX) begin
            data = OUT_MAX[OUT_WIDTH-1:0];
            sat  = 1'b1;
        end else if (shifted < OUT_MIN) begin
            data = OUT_MIN[OUT_WIDTH-1:0];
            sat  = 1'b1;
        end else begin
            data = shifted[OUT_WIDTH-1:0];
            sat  = 1'b0;
        end
        return {sat, data};
    endfunction

    // State
    logic signed [ACC_WIDTH-1:0] acc_r;
    logic [CNT_W-1:0]            cnt_r;
    logic [OUT_WIDTH-1:0]        out_data_r;
    logic                        out_sat_r;
    logic                        out_valid_r;

    // Combinational helpers
    logic                        last_s;
    logic                        in_ready_s;
    logic                        in_fire_s;
    logic                        load_s;
    logic                        out_fire_s;
    logic signed [ACC_WIDTH-1:0] in_sext_s;
    logic signed [ACC_WIDTH-1:0] sum_s;
    logic [OUT_WIDTH:0]          result_s;

    // Handshake decode. Only the row-completing term has to wait for the
    // output register; earlier terms keep accumulating while a result waits.
    always_comb begin
        last_s     = (cnt_r == LAST_CNT);
        in_ready_s = 1'b0;
        if (ce && reset) begin
            in_ready_s = !(last_s && out_valid_r && !out_ready);
        end else begin
            in_ready_s = 1'b0;
        end
        in_fire_s  = in_valid && in_ready_s;
        load_s     = in_fire_s && last_s;
        out_fire_s = out_valid_r && out_ready && ce;
    end

    // Running sum including the product on the input this cycle, and its
    // rescaled value used when this product completes the row.
    always_comb begin
        in_sext_s = $signed({{(ACC_WIDTH - IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data});
        sum_s     = acc_r + in_sext_s;
        result_s  = rescale(sum_s);
    end

    // Accumulator and term counter; both restart after the last term of a row.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_r <= ACC_ZERO;
            cnt_r <= CNT_ZERO;
        end else if (in_fire_s) begin
            if (last_s) begin
                acc_r <= ACC_ZERO;
                cnt_r <= CNT_ZERO;
            end else begin
                acc_r <= sum_s;
                cnt_r <= cnt_r + CNT_ONE;
            end
        end else begin
            acc_r <= acc_r;
            cnt_r <= cnt_r;
        end
    end

    // One-entry output register. A new result loading in the same cycle the
    // old one drains simply replaces it, so out_valid stays high with no gap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_data_r  <= OUT_ZERO;
            out_sat_r   <= 1'b0;
            out_valid_r <= 1'b0;
        end else if (load_s) begin
            out_data_r  <= result_s[OUT_WIDTH-1:0];
            out_sat_r   <= result_s[OUT_WIDTH];
            out_valid_r <= 1'b1;
        end else if (out_fire_s) begin
            out_data_r  <= out_data_r;
            out_sat_r   <= out_sat_r;
            out_valid_r <= 1'b0;
        end else begin
            out_data_r  <= out_data_r;
            out_sat_r   <= out_sat_r;
            out_valid_r <= out_valid_r;
        end
    end

    // Output drive
    assign in_ready  = in_ready_s;
    assign out_data  = out_data_r;
    assign out_sat   = out_sat_r;
    assign out_valid = out_valid_r;
    assign busy      = (cnt_r != CNT_ZERO);

endmodule

// File: tb/tb_mpc_dot_acc_36s_21s.sv
// ---------------------------------------------------------------------------
// Testbench for mpc_dot_acc_36s_21s (N_TERMS=4, SHIFT=14).
// The stimulus process drives inputs on the falling edge and keeps a
// reference model of the row in plain integer arithmetic; every completed
// row pushes its expected result into a queue. A separate monitor process
// compares the DUT output register against the queue head every cycle and
// pops on each output transfer.
// ---------------------------------------------------------------------------
module tb_mpc_dot_acc_36s_21s;

    localparam int N     = 4;
    localparam int IW    = 36;
    localparam int AW    = 42;
    localparam int SH    = 14;
    localparam int OW    = 21;

    typedef struct {
        logic [OW-1:0] data;
        logic          sat;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          ce;
    logic [IW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [OW-1:0] out_data;
    logic          out_sat;
    logic          out_valid;
    logic          out_ready;
    logic          busy;

    int   tests  = 0;
    int   fails  = 0;

    exp_t q[$];
    int     mcnt     = 0;
    longint msum     = 0;
    logic   accepted = 1'b0;
    logic   ordy_g   = 1'b1;

    mpc_dot_acc_36s_21s #(
        .N_TERMS  (N),
        .IN_WIDTH (IW),
        .ACC_WIDTH(AW),
        .SHIFT    (SH),
        .OUT_WIDTH(OW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ce       (ce),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_sat  (out_sat),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Reference: round half toward +inf, then clamp to the signed output range.
    function automatic exp_t row_result(input longint s);
        exp_t   e;
        longint r;
        longint maxv;
        longint minv;
        maxv = (longint'(1) <<< (OW - 1)) - 1;
        minv = -(longint'(1) <<< (OW - 1));
        r = (s + (longint'(1) <<< (SH - 1))) >>> SH;
        if (r > maxv) begin
            e.data = maxv[OW-1:0];
            e.sat  = 1'b1;
        end else if (r < minv) begin
            e.data = minv[OW-1:0];
            e.sat  = 1'b1;
        end else begin
            e.data = r[OW-1:0];
            e.sat  = 1'b0;
        end
        return e;
    endfunction

    function automatic logic [IW-1:0] to36(input longint v);
        return v[IW-1:0];
    endfunction

    // One clock cycle of stimulus plus the model's view of the input side.
    task automatic step(input logic iv, input logic [IW-1:0] d,
                        input logic cev, input logic ordy, input logic rstv);
        logic exp_rdy;
        @(negedge clk);
        in_valid  = iv;
        in_data   = d;
        ce        = cev;
        out_ready = ordy;
        reset     = rstv;
        if (!rstv) begin
            mcnt = 0;
            msum = 0;
            q.delete();
        end
        #4;
        exp_rdy = cev && rstv && !(mcnt == N - 1 && q.size() > 0 && !ordy);
        tests++;
        if (in_ready !== exp_rdy) begin
            fails++;
            $display("FAIL in_ready: got %b expected %b (cnt=%0d) t=%0t", in_ready, exp_rdy, mcnt, $time);
        end
        tests++;
        if (busy !== (mcnt != 0)) begin
            fails++;
            $display("FAIL busy: got %b expected %b t=%0t", busy, (mcnt != 0), $time);
        end
        accepted = iv && exp_rdy;
        if (accepted) begin
            msum = msum + longint'($signed(d));
            mcnt++;
            if (mcnt == N) begin
                q.push_back(row_result(msum));
                mcnt = 0;
                msum = 0;
            end
        end
    endtask

    // Hold a product on the input until it is accepted (bounded).
    task automatic send_term(input logic [IW-1:0] d);
        int n;
        n = 0;
        do begin
            step(1'b1, d, 1'b1, ordy_g, 1'b1);
            n++;
        end while (!accepted && n < 50);
        if (!accepted) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: got no accept expected accept within 50 cycles");
        end
    endtask

    task automatic send_row(input longint a, input longint b, input longint c, input longint e);
        send_term(to36(a));
        send_term(to36(b));
        send_term(to36(c));
        send_term(to36(e));
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, ordy, 1'b1);
    endtask

    function automatic logic [IW-1:0] rnd_prod();
        logic [63:0] w;
        w = {$urandom, $urandom};
        case ($urandom_range(0, 3))
            0:       return to36(longint'($signed(w[17:0])));
            1:       return w[IW-1:0];
            2:       return to36(longint'($signed(w[34:0])));
            default: return to36(longint'($urandom_range(0, 16383)) - 8192);
        endcase
    endfunction

    // Monitor: output register against the scoreboard head every cycle.
    initial begin
        exp_t e;
        logic exp_v;
        forever begin
            @(negedge clk);
            #3;
            exp_v = (q.size() > 0);
            tests++;
            if (out_valid !== exp_v) begin
                fails++;
                $display("FAIL out_valid: got %b expected %b t=%0t", out_valid, exp_v, $time);
            end
            if (out_valid === 1'b1 && exp_v) begin
                e = q[0];
                tests++;
                if (out_data !== e.data || out_sat !== e.sat) begin
                    fails++;
                    $display("FAIL out_data: got %0d sat %b expected %0d sat %b t=%0t",
                             $signed(out_data), out_sat, $signed(e.data), e.sat, $time);
                end
                if (out_ready && ce && reset) void'(q.pop_front());
            end
        end
    end

    initial begin
        int rows_done;
        int guard;
        reset     = 1'b0;
        ce        = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset state
        step(1'b0, '0, 1'b1, 1'b1, 1'b0);
        tests++;
        if (out_data !== '0 || out_sat !== 1'b0) begin
            fails++;
            $display("FAIL reset_out: got %0h/%b expected 0/0", out_data, out_sat);
        end
        step(1'b0, '0, 1'b1, 1'b1, 1'b0);
        idle(2, 1'b1);

        // Basic and rounding boundaries
        ordy_g = 1'b1;
        send_row(16384, 16384, 16384, 16384);
        send_row(8192, 0, 0, 0);
        send_row(8191, 0, 0, 0);
        send_row(-8192, 0, 0, 0);
        send_row(-8193, 0, 0, 0);
        // Saturation both ways
        send_row(longint'(1) <<< 34, longint'(1) <<< 34, longint'(1) <<< 34, longint'(1) <<< 34);
        send_row(-(longint'(1) <<< 34), -(longint'(1) <<< 34), -(longint'(1) <<< 34), -(longint'(1) <<< 34));
        idle(3, 1'b1);

        // Backpressure: first result waits, last term of row two stalls
        ordy_g = 1'b0;
        for (int i = 0; i < 7; i++) send_term(to36(16384));
        for (int i = 0; i < 3; i++) step(1'b1, to36(16384), 1'b1, 1'b0, 1'b1);
        ordy_g = 1'b1;
        send_term(to36(16384));
        idle(3, 1'b1);

        // Gaps and ce=0 mid-row, ce=0 blocking the output transfer
        send_term(to36(123456));
        step(1'b0, '0, 1'b1, 1'b1, 1'b1);
        step(1'b1, to36(-7777), 1'b0, 1'b1, 1'b1);
        send_term(to36(-7777));
        step(1'b1, to36(99), 1'b0, 1'b0, 1'b1);
        send_term(to36(99));
        send_term(to36(5000000));
        step(1'b0, '0, 1'b0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1, 1'b1);
        idle(2, 1'b1);

        // Reset mid-row
        send_term(to36(16384));
        send_term(to36(16384));
        step(1'b0, '0, 1'b1, 1'b1, 1'b0);
        tests++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset: got busy %b valid %b expected 0/0", busy, out_valid);
        end
        step(1'b0, '0, 1'b1, 1'b1, 1'b1);
        send_row(16384, 16384, 16384, 16384);
        idle(3, 1'b1);

        // Randomised rows with gaps, ce drops and backpressure
        rows_done = 0;
        guard     = 0;
        while (rows_done < 30 && guard < 5000) begin
            step($urandom_range(0, 3) != 0, rnd_prod(), $urandom_range(0, 4) != 0,
                 $urandom_range(0, 2) != 0, 1'b1);
            if (accepted && mcnt == 0) rows_done++;
            guard++;
        end
        if (rows_done < 30) begin
            tests++;
            fails++;
            $display("FAIL random_rows: got %0d expected 30", rows_done);
        end

        // Drain and confirm every expected result was delivered
        idle(5, 1'b1);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mpc_dot_acc_36s_21s.md
Name: mpc_dot_acc_36s_21s

Overview:
- Sits directly downstream of the 21s x 15ns -> 36-bit, 4-stage multiplier in the implicit-MPC datapath.
- Consumes its stream of signed 36-bit products and accumulates N_TERMS products per row (matrix-row x vector dot product).
- Rescales each row sum to the 21-bit signed fixed-point format with round-half-up and saturation.
- Presents the result on a valid/ready output held in a one-entry output register.

Parameters:
- N_TERMS, 8, products per dot product (>=2, <=64).
- IN_WIDTH, 36, product width (signed two's complement).
- ACC_WIDTH, 42, accumulator width (IN_WIDTH + 6 guard bits; no internal overflow for N_TERMS<=64).
- SHIFT, 14, fractional bits dropped when rescaling (>=1).
- OUT_WIDTH, 21, result width (signed).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 clears all state).
- ce  in  1  clock enable; 0 freezes every register and blocks both handshakes.
- in_data  in  IN_WIDTH  signed product from multiplier.
- in_valid  in  1  in_data valid (multiplier issue valid delayed 4 cycles by the producer).
- in_ready  out  1  block accepts in_data this cycle.
- out_data  out  OUT_WIDTH  rounded, saturated row result.
- out_sat  out  1  out_data was clamped.
- out_valid  out  1  out_data/out_sat valid.
- out_ready  in  1  consumer accepts output.
- busy  out  1  a row is partially accumulated (term count != 0).

Behaviour:
- Reset (reset=0, async):
  - acc=0, cnt=0, out_valid=0, out_data=0, out_sat=0, busy=0.
  - in_ready is combinational and reads 0 while reset is asserted.
- Input transfer: in_valid && in_ready && ce.
- Output transfer: out_valid && out_ready && ce.
- Counter cnt runs 0..N_TERMS-1. Each transfer with cnt<N_TERMS-1:
  - acc <= acc + sext(in_data);
  - cnt++.
- Last term (transfer with cnt==N_TERMS-1):
  - sum = acc + sext(in_data) (combinational, ACC_WIDTH).
  - r = (sum + 2^(SHIFT-1)) >>> SHIFT (arithmetic shift; round half toward +inf).
  - If r > 2^(OUT_WIDTH-1)-1: out_data = 2^(OUT_WIDTH-1)-1, out_sat=1.
  - Else if r < -2^(OUT_WIDTH-1): out_data = -2^(OUT_WIDTH-1), out_sat=1.
  - Else out_data = r[OUT_WIDTH-1:0], out_sat=0.
  - out_valid <= 1; acc <= 0; cnt <= 0.
- Latency: out_valid rises on the clock edge that accepts the last term (result visible the cycle after last-term accept).
- in_ready = ce && reset && !(cnt==N_TERMS-1 && out_valid && !out_ready).
  - Accumulation continues while a result waits.
  - Only completion of the next row stalls on a full output register.
- Output register:
  - out_valid clears on output transfer unless a new result loads in the same cycle, in which case the new result replaces it and out_valid stays 1 (no bubble, no loss).
  - out_data/out_sat are stable while out_valid=1 && !out_ready.
- in_valid=0 cycles: no change (gaps allowed anywhere in a row).
- ce=0: all registers hold, in_ready=0, no output transfer even if out_ready=1.
- busy = (cnt != 0).
- Reset mid-row: partial sum and count discarded; the next accepted product starts a new row.
- Accumulator never wraps for legal parameters; no overflow detection internal to acc.

Test Plan (N_TERMS=4, SHIFT=14, defaults otherwise):
- Basic: four products of 16384, out_ready=1 -> out_data=4, out_sat=0, out_valid pulses 1 cycle after 4th accept.
- Rounding:
  - row sum 8192 (8192,0,0,0) -> 1;
  - sum 8191 -> 0;
  - sum -8192 -> 0;
  - sum -8193 -> -1.
- Saturation:
  - four products of 2^34 -> out_data=1048575, out_sat=1;
  - four of -2^34 -> -1048576, out_sat=1.
- Backpressure: out_ready=0, stream 8 products of 16384 continuously:
  - first result held at 4;
  - in_ready=0 only while cnt==3;
  - raise out_ready -> result 4 drains, 4th term accepted that cycle, second result 4 appears with no gap.
- ce/gaps: insert in_valid=0 and ce=0 cycles mid-row -> result identical to gap-free run; no handshakes fire while ce=0.
- Reset mid-row: accept 2 products of 16384, assert reset for 1 cycle -> busy=0, out_valid=0; next 4 products of 16384 -> out_data=4.
